life_evolver: RTL and testbench

- Streaming next-generation engine for the Game-of-Life core.
- Sits between the "current generation" RAM read port and the "next generation" RAM write port of the ping-pong RAM pair, driven by the 1 Hz-class evolution enable.
- Scans the grid once per generation in row-major order, one cell per clock, using two line buffers and a 3x3 window.
- Emits each cell's next state with a fixed latency.

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_line_buffer.sv | 37 +++
 rtl/life_evolver.sv | 229 ++++++++++++++++++++++
 tb/tb_life_evolver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types, default grid size and the Game-of-Life rule
//                used by the next-generation engine.
//  Revision    : 1.0  initial release
// ============================================================================
package life_pkg;

  // Default grid size (rows x columns)
  localparam int C_DEF_M = 600;
  localparam int C_DEF_N = 800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } evo_state_t;

  // Birth on exactly three neighbours, survival on two or three
  function automatic logic life_rule(input logic centre, input logic [3:0] n);
    return (n == 4'd3) | (centre & (n == 4'd2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : life_line_buffer
//  Description : DEPTH-deep 1-bit shift delay. dout is the oldest bit, i.e.
//                the value that falls out on the next enabled shift.
//                Contents need no reset: the window edge masks hide them.
//  Revision    : 1.0  initial release
// ============================================================================
module life_line_buffer #(
  parameter int DEPTH = 800
) (
  input  logic clk,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  assign dout = r_sr[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay
      always_ff @(posedge clk) begin
        if (en) r_sr <= din;
      end
    end else begin : g_chain
      // Shift one position per accepted bit
      always_ff @(posedge clk) begin
        if (en) r_sr <= {r_sr[DEPTH-2:0], din};
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/life_evolver.sv
`default_nettype none
// ============================================================================
//  Module      : life_evolver
//  Description : Streaming next-generation engine. Reads the current grid in
//                row-major order, one cell per clock, builds a 3x3 window
//                from two line buffers and writes each cell's next state
//                N+3 cycles after its read.
//                Optional macro LIFE_EVOLVER_POP_COUNT_EN adds a population
//                counter on pop_count (tied to 0 otherwise).
//  Revision    : 1.0  initial release
// ============================================================================
module life_evolver
  import life_pkg::*;
#(
  parameter int P_PARAM_M = C_DEF_M,
  parameter int P_PARAM_N = C_DEF_N,
  parameter int ADDR_W    = 24,
  parameter int COORD_W   = 12,
  parameter int CNT_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_evo_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_data,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_val,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [CNT_W-1:0]  pop_count
);

  // Last cell address, last accepted input index (N+1 dead cells past the
  // grid) and the first input index whose window centre is a real cell.
  localparam logic [ADDR_W-1:0]  C_LAST_ADDR = ADDR_W'(P_PARAM_M * P_PARAM_N - 1);
  localparam logic [ADDR_W-1:0]  C_FLUSH_END = ADDR_W'(P_PARAM_M * P_PARAM_N + P_PARAM_N);
  localparam logic [ADDR_W-1:0]  C_WIN_START = ADDR_W'(P_PARAM_N + 1);
  localparam logic [COORD_W-1:0] C_LAST_ROW  = COORD_W'(P_PARAM_M - 1);
  localparam logic [COORD_W-1:0] C_LAST_COL  = COORD_W'(P_PARAM_N - 1);

  evo_state_t         r_state, w_state_nxt;
  logic               r_evo_q, w_req, w_start;
  logic [ADDR_W-1:0]  r_raddr, r_in_cnt, r_waddr;
  logic               r_rd_vld, w_accept, w_din;
  logic               w_lb1_out, w_lb2_out;
  logic [2:0]         r_top, r_mid, r_bot;
  logic               r_win_vld, r_last_wr, w_last_write, r_overrun;
  logic [COORD_W-1:0] r_wrow, r_wcol;
  logic [7:0]         w_nb;
  logic [3:0]         w_n;

  assign w_req   = global_evo_en ^ r_evo_q;
  assign w_start = (r_state == IDLE) && w_req;

  // Real read data while a read is returning, otherwise a dead flush cell
  assign w_accept = r_rd_vld | ((r_state == FLUSH) && (r_in_cnt <= C_FLUSH_END));
  assign w_din    = r_rd_vld & read_data;

  assign w_last_write = r_win_vld && (r_waddr == C_LAST_ADDR);

  // Previous enable level for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_evo_q <= 1'b0;
    else     r_evo_q <= global_evo_en;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    read_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (w_req) w_state_nxt = READ;
      READ: begin
        read_en = 1'b1;
        busy    = 1'b1;
        if (r_raddr == C_LAST_ADDR) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (r_last_wr) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read address sweep and one-cycle read-return flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= (r_state == READ);
      if (w_start)
        r_raddr <= '0;
      else if ((r_state == READ) && (r_raddr != C_LAST_ADDR))
        r_raddr <= r_raddr + ADDR_W'(1);
    end
  end

  assign read_addr = r_raddr;

  life_line_buffer #(.DEPTH(P_PARAM_N)) u_lb1 (
    .clk  (clk),
    .en   (w_accept),
    .din  (w_din),
    .dout (w_lb1_out)
  );

  life_line_buffer #(.DEPTH(P_PARAM_N)) u_lb2 (
    .clk  (clk),
    .en   (w_accept),
    .din  (w_lb1_out),
    .dout (w_lb2_out)
  );

  // Input index counter and 3x3 window columns; bit 0 is the right column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt  <= '0;
      r_top     <= '0;
      r_mid     <= '0;
      r_bot     <= '0;
      r_win_vld <= 1'b0;
    end else begin
      r_win_vld <= w_accept && (r_in_cnt >= C_WIN_START);
      if (w_start)
        r_in_cnt <= '0;
      else if (w_accept)
        r_in_cnt <= r_in_cnt + ADDR_W'(1);
      if (w_accept) begin
        r_bot <= {r_bot[1:0], w_din};
        r_mid <= {r_mid[1:0], w_lb1_out};
        r_top <= {r_top[1:0], w_lb2_out};
      end
    end
  end

  // Coordinates of the current window centre, advanced after each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr   <= '0;
      r_wrow    <= '0;
      r_wcol    <= '0;
      r_last_wr <= 1'b0;
    end else if (w_start) begin
      r_waddr   <= '0;
      r_wrow    <= '0;
      r_wcol    <= '0;
      r_last_wr <= 1'b0;
    end else if (w_last_write) begin
      r_last_wr <= 1'b1;
    end else if (r_win_vld) begin
      r_waddr <= r_waddr + ADDR_W'(1);
      if (r_wcol == C_LAST_COL) begin
        r_wcol <= '0;
        r_wrow <= r_wrow + COORD_W'(1);
      end else begin
        r_wcol <= r_wcol + COORD_W'(1);
      end
    end
  end

  // Edge-masked neighbour count (no wrap-around)
  always_comb begin
    w_nb[0] = r_top[2] & (r_wrow != '0) & (r_wcol != '0);
    w_nb[1] = r_top[1] & (r_wrow != '0);
    w_nb[2] = r_top[0] & (r_wrow != '0) & (r_wcol != C_LAST_COL);
    w_nb[3] = r_mid[2] & (r_wcol != '0);
    w_nb[4] = r_mid[0] & (r_wcol != C_LAST_COL);
    w_nb[5] = r_bot[2] & (r_wrow != C_LAST_ROW) & (r_wcol != '0);
    w_nb[6] = r_bot[1] & (r_wrow != C_LAST_ROW);
    w_nb[7] = r_bot[0] & (r_wrow != C_LAST_ROW) & (r_wcol != C_LAST_COL);
    w_n = 4'd0;
    for (int i = 0; i < 8; i++) w_n = w_n + 4'(w_nb[i]);
  end

  assign write_en   = r_win_vld;
  assign write_addr = r_waddr;
  assign write_val  = r_win_vld & life_rule(r_mid[1], w_n);

  // Sticky overrun: any request not accepted from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_overrun <= 1'b0;
    else if (w_start)                    r_overrun <= 1'b0;
    else if (w_req && (r_state != IDLE)) r_overrun <= 1'b1;
  end

  assign overrun = r_overrun;

`ifdef LIFE_EVOLVER_POP_COUNT_EN
  logic [CNT_W-1:0] r_pop_acc, r_pop;

  // Live-cell accumulator, published in the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_acc <= '0;
      r_pop     <= '0;
    end else begin
      if (w_start)
        r_pop_acc <= '0;
      else if (write_en && write_val)
        r_pop_acc <= r_pop_acc + CNT_W'(1);
      if (r_state == DONE)
        r_pop <= r_pop_acc;
    end
  end

  assign pop_count = r_pop;
`else
  assign pop_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_evolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_evolver
//  Description : Self-checking bench for life_evolver on a 5x6 grid with a
//                one-cycle-latency RAM model and a Game-of-Life reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_evolver;

  localparam int M = 5;
  localparam int N = 6;
  localparam int CELLS = M * N;

  localparam int CMD_CLEAR  = 0;
  localparam int CMD_RST    = 1;
  localparam int CMD_GEN    = 2;
  localparam int CMD_NODONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        evo = 1'b0;
  logic        read_en, write_en, write_val, busy, done, overrun;
  logic [23:0] read_addr, write_addr;
  logic        rd_q = 1'b0;
  logic [19:0] pop_count;

  // Stimulus-side state (written only by the main process)
  logic [CELLS-1:0] mem = '0;
  logic [CELLS-1:0] exp_next = '0;
  int               exp_pop = 0;
  logic [31:0]      exp_lit = '0;
  int               exp_ovr = 0;
  int               cmd = 0;
  int               cmd_seq = 0;

  // Checker-side state (written only by the compare process)
  int          n_tests = 0, n_fail = 0, ack = 0, cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int          first_busy = 0, done_cyc = 0, first_rd = 0, first_wr = 0;
  int          rd_cyc [CELLS];
  logic [31:0] dut_vec = '0;

  life_evolver #(
    .P_PARAM_M (M),
    .P_PARAM_N (N),
    .ADDR_W    (24),
    .COORD_W   (12),
    .CNT_W     (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .global_evo_en (evo),
    .read_en       (read_en),
    .read_addr     (read_addr),
    .read_data     (rd_q),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_val     (write_val),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .pop_count     (pop_count)
  );

  always #5 clk = ~clk;

  // Current-generation RAM, data one cycle after the read
  always @(posedge clk) begin
    if (read_en && read_addr < 24'(CELLS)) rd_q <= mem[read_addr[4:0]];
    else                                   rd_q <= 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, plus end-of-phase checks on command
  always @(negedge clk) begin
    cyc++;
    if (ack != cmd_seq) begin
      case (cmd)
        CMD_CLEAR: begin
          wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; dut_vec = '0;
          first_busy = -1000; done_cyc = 0; first_rd = -1000; first_wr = 0;
        end
        CMD_RST: begin
          chk("rst_read_en", int'(read_en), 0);
          chk("rst_write_en", int'(write_en), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_done", int'(done), 0);
          chk("rst_overrun", int'(overrun), 0);
          chk("rst_pop_count", int'(pop_count), 0);
        end
        CMD_GEN: begin
          chk("write_count", wr_cnt, CELLS);
          chk("done_pulses", done_cnt, 1);
          chk("busy_cycles", busy_cnt, CELLS + N + 4);
          chk("done_after_busy", done_cyc - first_busy, CELLS + N + 4);
          chk("first_write_latency", first_wr - first_rd, N + 3);
          chk("grid_vs_literal", int'(dut_vec), int'(exp_lit));
          chk("overrun", int'(overrun), exp_ovr);
          chk("busy_after_done", int'(busy), 0);
`ifdef LIFE_EVOLVER_POP_COUNT_EN
          chk("pop_count", int'(pop_count), exp_pop);
`endif
        end
        CMD_NODONE: begin
          chk("no_done_after_rst", done_cnt, 0);
          chk("idle_after_rst", int'(busy), 0);
        end
        default: ;
      endcase
      ack = cmd_seq;
    end
    if (read_en) begin
      chk("read_addr_seq", int'(read_addr), rd_cnt);
      if (read_addr < 24'(CELLS)) rd_cyc[read_addr[4:0]] = cyc;
      if (read_addr == 24'd0) first_rd = cyc;
      rd_cnt++;
    end
    if (write_en) begin
      chk("write_addr_seq", int'(write_addr), wr_cnt);
      if (write_addr < 24'(CELLS)) begin
        chk("write_val", int'(write_val), int'(exp_next[write_addr[4:0]]));
        chk("write_latency", cyc - rd_cyc[write_addr[4:0]], N + 3);
        dut_vec[write_addr[4:0]] = write_val;
      end
      if (write_addr == 24'd0) first_wr = cyc;
      wr_cnt++;
    end
    if (busy) begin
      if (busy_cnt == 0) first_busy = cyc;
      busy_cnt++;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  // Reference next generation from neighbour counts on the bounded grid
  task automatic model_next();
    int n;
    exp_pop = 0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < M &&
                c + dc >= 0 && c + dc < N)
              n += int'(mem[(r + dr) * N + c + dc]);
        exp_next[r * N + c] = (n == 3) || (mem[r * N + c] && n == 2);
        exp_pop += int'(exp_next[r * N + c]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int c);
    cmd = c;
    cmd_seq++;
    for (int i = 0; i < 4 && ack != cmd_seq; i++) step();
    if (ack != cmd_seq) begin
      $display("FAIL checker_handshake: got %0d, expected %0d", ack, cmd_seq);
      $fatal(1);
    end
  endtask

  task automatic run_gen(input logic [CELLS-1:0] grid, input logic [31:0] lit,
                         input int ovr_at, input int tail, input int e_ovr);
    mem = grid;
    model_next();
    exp_lit = lit;
    exp_ovr = e_ovr;
    issue(CMD_CLEAR);
    evo = ~evo;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      step();
      if (i == ovr_at) evo = ~evo;
    end
    repeat (tail) step();
    issue(CMD_GEN);
  endtask

  localparam logic [CELLS-1:0] G_BLINK = 30'h0010_4100;  // (1,2),(2,2),(3,2)
  localparam logic [CELLS-1:0] G_BLOCK = 30'h0000_00C3;  // (0..1,0..1)
  localparam logic [CELLS-1:0] G_FULL  = 30'h3FFF_FFFF;
  localparam logic [CELLS-1:0] G_EMPTY = 30'h0000_0000;

  initial begin
    repeat (3) step();
    issue(CMD_RST);
    rst = 1'b0;
    repeat (3) step();

    // Vertical blinker becomes horizontal (2,1..3)
    run_gen(G_BLINK, 32'h0000_E000, -1, 5, 0);
    // Corner block is still
    run_gen(G_BLOCK, 32'h0000_00C3, -1, 5, 0);
    // Full grid: only the four corners survive
    run_gen(G_FULL, 32'h2100_0021, -1, 5, 0);
    // Second toggle while busy: overrun, no second generation
    run_gen(G_BLINK, 32'h0000_E000, 10, 60, 1);
    // Empty grid; accepted start clears overrun
    run_gen(G_EMPTY, 32'h0000_0000, -1, 5, 0);

    // Reset in the middle of a generation
    mem = G_BLINK;
    model_next();
    issue(CMD_CLEAR);
    evo = ~evo;
    repeat (21) step();
    rst = 1'b1;
    evo = 1'b0;
    issue(CMD_RST);
    repeat (2) step();
    rst = 1'b0;
    repeat (50) step();
    issue(CMD_NODONE);
    run_gen(G_BLINK, 32'h0000_E000, -1, 5, 0);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
